// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch path: the machine word and the fetch sequencer
// state/increment definitions.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

package fetch_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_INC = 32'd4;
endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + ONE;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/fetch_sequencer.sv
// PC / imem-read controller: sequential advance, stall hold, branch redirect
// (including a redirect landing on an outstanding miss), and halt parking.
module fetch_sequencer
    import cpu_types_pkg::*;
    import fetch_pkg::*;
#(
    parameter word_t       PC_INC = fetch_pkg::PC_INC,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic [31:0]      imemaddr,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    input  logic             halt,
    output logic [31:0]      next_pc,
    output logic             enable_pc,
    output logic             iREN,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [1:0]       fetch_state,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] squash_cnt
);
    fetch_state_t r_state;
    fetch_state_t w_next_state;
    word_t        r_pend_tgt;
    logic         w_pend_load;
    logic         w_fetch_inc;
    logic         w_squash_inc;
    logic         w_flush;
    logic         w_write;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= FETCH;
            r_pend_tgt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pend_load)
                r_pend_tgt <= redirect_target;
        end
    end

    always_comb begin
        w_next_state = r_state;
        next_pc      = imemaddr;
        enable_pc    = 1'b0;
        iREN         = 1'b1;
        w_write      = 1'b0;
        w_flush      = 1'b0;
        w_pend_load  = 1'b0;
        w_fetch_inc  = 1'b0;
        w_squash_inc = 1'b0;

        case (r_state)
            FETCH: begin
                if (redirect) begin
                    w_flush = 1'b1;
                    if (ihit) begin
                        next_pc      = redirect_target;
                        enable_pc    = 1'b1;
                        w_squash_inc = 1'b1;
                    end else begin
                        w_pend_load  = 1'b1;
                        w_next_state = SQUASH;
                    end
                end else if (!stall) begin
                    if (ihit) begin
                        next_pc     = imemaddr + PC_INC;
                        enable_pc   = 1'b1;
                        w_write     = 1'b1;
                        w_fetch_inc = 1'b1;
                    end else begin
                        w_flush = 1'b1;
                    end
                end
            end
            SQUASH: begin
                // The miss in flight is wrong-path; a redirect arriving now is
                // younger than the pending one, so it replaces the target.
                w_flush = 1'b1;
                if (redirect)
                    w_pend_load = 1'b1;
                if (ihit) begin
                    next_pc      = redirect ? redirect_target : r_pend_tgt;
                    enable_pc    = 1'b1;
                    w_squash_inc = 1'b1;
                    w_next_state = FETCH;
                end
            end
            HALTED: begin
                iREN    = 1'b0;
                w_flush = 1'b1;
            end
            default: w_next_state = FETCH;
        endcase

        if (halt) begin
            w_next_state = HALTED;
            next_pc      = imemaddr;
            enable_pc    = 1'b0;
            w_write      = 1'b0;
            w_flush      = 1'b1;
            w_pend_load  = 1'b0;
            w_fetch_inc  = 1'b0;
            w_squash_inc = 1'b0;
        end
    end

    // IF/ID controls stay quiet while the core is held in reset.
    assign ifid_write  = w_write & nRST;
    assign ifid_flush  = w_flush & nRST;
    assign fetch_state = r_state;

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_inc   (w_fetch_inc),
        .o_cnt   (fetch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_squash_cnt (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_inc   (w_squash_inc),
        .o_cnt   (squash_cnt)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic checked against a rule-level reference model.
module tb_fetch_sequencer;
    import cpu_types_pkg::*;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit, stall, redirect, halt;
    word_t         imemaddr, redirect_target;
    word_t         next_pc;
    logic          enable_pc, iREN, ifid_write, ifid_flush;
    logic [1:0]    fetch_state;
    logic [CW-1:0] fetch_cnt, squash_cnt;

    fetch_sequencer #(.PC_INC(32'd4), .CNT_W(CW)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .ihit            (ihit),
        .imemaddr        (imemaddr),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .next_pc         (next_pc),
        .enable_pc       (enable_pc),
        .iREN            (iREN),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .fetch_state     (fetch_state),
        .fetch_cnt       (fetch_cnt),
        .squash_cnt      (squash_cnt)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: halted flag, pending-redirect flag/target, counts.
    bit          m_halted;
    bit          m_pend;
    word_t       m_tgt;
    int unsigned m_fcnt, m_scnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0;
        m_pend   = 1'b0;
        m_tgt    = '0;
        m_fcnt   = 0;
        m_scnt   = 0;
    endtask

    function automatic logic [1:0] m_state();
        return m_halted ? 2'd2 : (m_pend ? 2'd1 : 2'd0);
    endfunction

    task automatic check_outputs();
        bit    e_en, e_wr, e_fl, e_ir;
        word_t e_npc;
        e_en = 0; e_wr = 0; e_fl = 0; e_ir = 1; e_npc = imemaddr;
        if (m_halted) begin
            e_ir = 0; e_fl = 1;
        end else if (halt) begin
            e_fl = 1;
        end else if (m_pend) begin
            e_fl = 1;
            if (ihit) begin
                e_en  = 1;
                e_npc = redirect ? redirect_target : m_tgt;
            end
        end else if (redirect) begin
            e_fl = 1;
            if (ihit) begin
                e_en  = 1;
                e_npc = redirect_target;
            end
        end else if (!stall) begin
            if (ihit) begin
                e_en = 1; e_wr = 1; e_npc = imemaddr + 32'd4;
            end else begin
                e_fl = 1;
            end
        end
        chk("enable_pc",   {63'd0, enable_pc},  {63'd0, e_en});
        chk("next_pc",     {32'd0, next_pc},    {32'd0, e_npc});
        chk("ifid_write",  {63'd0, ifid_write}, {63'd0, e_wr});
        chk("ifid_flush",  {63'd0, ifid_flush}, {63'd0, e_fl});
        chk("iREN",        {63'd0, iREN},       {63'd0, e_ir});
        chk("fetch_state", {62'd0, fetch_state}, {62'd0, m_state()});
    endtask

    task automatic model_step();
        if (m_halted) begin
        end else if (halt) begin
            m_halted = 1;
        end else if (m_pend) begin
            if (redirect) m_tgt = redirect_target;
            if (ihit) begin
                m_pend = 0;
                if (m_scnt < CMAX) m_scnt++;
            end
        end else if (redirect) begin
            if (ihit) begin
                if (m_scnt < CMAX) m_scnt++;
            end else begin
                m_pend = 1;
                m_tgt  = redirect_target;
            end
        end else if (!stall && ihit) begin
            if (m_fcnt < CMAX) m_fcnt++;
        end
    endtask

    task automatic drive(input bit h, input word_t a, input bit s, input bit r,
                         input word_t t, input bit hl);
        ihit = h; imemaddr = a; stall = s; redirect = r; redirect_target = t; halt = hl;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        chk("fetch_cnt",   {{(64-CW){1'b0}}, fetch_cnt},  64'(m_fcnt));
        chk("squash_cnt",  {{(64-CW){1'b0}}, squash_cnt}, 64'(m_scnt));
        chk("state_after", {62'd0, fetch_state}, {62'd0, m_state()});
    endtask

    task automatic do_reset();
        ihit = 0; stall = 0; redirect = 0; halt = 0; imemaddr = 32'h40; redirect_target = '0;
        nRST = 0;
        model_reset();
        #2;
        chk("rst_state",  {62'd0, fetch_state}, 64'd0);
        chk("rst_en",     {63'd0, enable_pc},   64'd0);
        chk("rst_write",  {63'd0, ifid_write},  64'd0);
        chk("rst_flush",  {63'd0, ifid_flush},  64'd0);
        chk("rst_iren",   {63'd0, iREN},        64'd1);
        chk("rst_fcnt",   {{(64-CW){1'b0}}, fetch_cnt},  64'd0);
        chk("rst_scnt",   {{(64-CW){1'b0}}, squash_cnt}, 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    initial begin
        int    halted_cycles;
        bit    h, s, r, hl;
        word_t a, t;

        nRST = 1;
        ihit = 0; stall = 0; redirect = 0; halt = 0; imemaddr = '0; redirect_target = '0;
        #3;
        do_reset();

        // Sequential hit from address 0
        drive(1, 32'h0, 0, 0, 32'h0, 0);
        chk("seq_npc", {32'd0, next_pc}, 64'h4);
        tick();
        chk("seq_fcnt", {{(64-CW){1'b0}}, fetch_cnt}, 64'd1);

        // Three misses then a hit at 0x10
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h10, 0, 0, 32'h0, 0);
            tick();
        end
        drive(1, 32'h10, 0, 0, 32'h0, 0);
        chk("miss_then_hit_npc", {32'd0, next_pc}, 64'h14);
        tick();

        // Redirect on a miss, two more misses, then the hit lands on the target
        drive(0, 32'h14, 0, 1, 32'h200, 0);
        tick();
        chk("squash_entered", {62'd0, fetch_state}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h14, 0, 0, 32'h0, 0);
            tick();
        end
        drive(1, 32'h14, 0, 0, 32'h0, 0);
        chk("squash_npc", {32'd0, next_pc}, 64'h200);
        tick();
        chk("squash_cnt1", {{(64-CW){1'b0}}, squash_cnt}, 64'd1);

        // Redirect beats stall
        drive(1, 32'h200, 1, 1, 32'h80, 0);
        chk("redir_over_stall", {32'd0, next_pc}, 64'h80);
        tick();

        // Stall holds pc even on hit
        drive(1, 32'h80, 1, 0, 32'h0, 0);
        tick();

        // PC wrap
        drive(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0);
        chk("wrap_npc", {32'd0, next_pc}, 64'h0);
        tick();

        // Youngest redirect wins inside SQUASH
        drive(0, 32'h0, 0, 1, 32'h100, 0);
        tick();
        drive(0, 32'h0, 0, 1, 32'h180, 0);
        tick();
        drive(1, 32'h0, 0, 0, 32'h0, 0);
        chk("youngest_wins", {32'd0, next_pc}, 64'h180);
        tick();

        // Halt mid-SQUASH parks fetch until reset
        drive(0, 32'h180, 0, 1, 32'h300, 0);
        tick();
        drive(1, 32'h180, 0, 0, 32'h0, 1);
        tick();
        chk("halted_state", {62'd0, fetch_state}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h180, 0, 1, 32'h500, 0);
            chk("halted_en", {63'd0, enable_pc}, 64'd0);
            tick();
        end
        do_reset();

        // Reset mid-SQUASH drops the pending target
        drive(0, 32'h0, 0, 1, 32'h700, 0);
        tick();
        do_reset();
        drive(1, 32'h0, 0, 0, 32'h0, 0);
        chk("rst_drops_pend", {32'd0, next_pc}, 64'h4);
        tick();

        // Randomized traffic against the model
        halted_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_halted && halted_cycles >= 3) begin
                do_reset();
                halted_cycles = 0;
            end
            h  = ($urandom_range(0, 99) < 55);
            s  = ($urandom_range(0, 99) < 25);
            r  = ($urandom_range(0, 99) < 15);
            hl = ($urandom_range(0, 99) < 2);
            a  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            t  = $urandom & 32'hFFFF_FFFC;
            if (m_pend && r) h = 0;
            drive(h, a, s, r, t, hl);
            tick();
            if (m_halted) halted_cycles++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
